// File: rtl/sal_ddr_pkg.sv
// Shared DDR2 controller types: the decoded read request carried from AR ingress
// to the scheduler, plus AXI encodings used by the ingress checks.
package sal_ddr_pkg;

  localparam int SAL_ID_WIDTH  = 4;
  localparam int SAL_LEN_WIDTH = 4;
  localparam int SAL_BA_WIDTH  = 2;
  localparam int SAL_RA_WIDTH  = 14;
  localparam int SAL_CA_WIDTH  = 10;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [SAL_ID_WIDTH-1:0]  id;
    logic [SAL_LEN_WIDTH-1:0] len;
    logic [SAL_BA_WIDTH-1:0]  ba;
    logic [SAL_RA_WIDTH-1:0]  ra;
    logic [SAL_CA_WIDTH-1:0]  ca;
  } sal_rd_req_t;

endpackage

// File: rtl/sal_ar_ingress_fifo.sv
// SAL_FIFO: small synchronous FIFO with registered storage and an occupancy count.
// The head entry is presented combinationally so it stays stable until popped.
module SAL_FIFO #(
  parameter int DEPTH_LG2  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LG2-1:0]  wr_ptr;
  logic [DEPTH_LG2-1:0]  rd_ptr;
  logic [DEPTH_LG2:0]    count;

  assign full     = (count == (DEPTH_LG2+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Simultaneous push and pop leaves the count unchanged, even when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sal_ar_ingress.sv
// AXI read-address ingress: decodes AR beats into bank/row/column requests, queues
// them in order for the scheduler and caps the number of reads in flight.
module sal_ar_ingress
  import sal_ddr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = SAL_ID_WIDTH,
  parameter int LEN_WIDTH       = SAL_LEN_WIDTH,
  parameter int BYTE_LG2        = 4,
  parameter int CA_WIDTH        = SAL_CA_WIDTH,
  parameter int BA_WIDTH        = SAL_BA_WIDTH,
  parameter int RA_WIDTH        = SAL_RA_WIDTH,
  parameter int FIFO_DEPTH_LG2  = 2,
  parameter int MAX_OUTSTANDING = 16,
  localparam int OUT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [LEN_WIDTH-1:0]  arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ID_WIDTH-1:0]   req_id,
  output logic [LEN_WIDTH-1:0]  req_len,
  output logic [BA_WIDTH-1:0]   req_ba,
  output logic [RA_WIDTH-1:0]   req_ra,
  output logic [CA_WIDTH-1:0]   req_ca,
  input  logic                  rd_done,
  output logic [OUT_WIDTH-1:0]  outstanding,
  output logic                  err
);

  sal_rd_req_t push_req;
  sal_rd_req_t head_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        run;
  logic        ar_hs;
  logic        req_hs;
  logic        proto_err;
  logic [CA_WIDTH:0] col_end;

  // Holds arready low through reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign arready   = run & ~fifo_full & (outstanding < OUT_WIDTH'(MAX_OUTSTANDING));
  assign ar_hs     = arvalid & arready;
  assign req_valid = ~fifo_empty;
  assign req_hs    = req_valid & req_ready;

  assign push_req.id  = arid;
  assign push_req.len = arlen;
  assign push_req.ca  = araddr[BYTE_LG2 +: CA_WIDTH];
  assign push_req.ba  = araddr[BYTE_LG2 + CA_WIDTH +: BA_WIDTH];
  assign push_req.ra  = araddr[BYTE_LG2 + CA_WIDTH + BA_WIDTH +: RA_WIDTH];

  // A carry out of the column field means the burst would cross into the next row.
  assign col_end   = {1'b0, push_req.ca} + (CA_WIDTH+1)'(arlen);
  assign proto_err = (arburst != AXI_BURST_INCR) || (arsize != 3'(BYTE_LG2)) || col_end[CA_WIDTH];

  SAL_FIFO #(
    .DEPTH_LG2  (FIFO_DEPTH_LG2),
    .DATA_WIDTH ($bits(sal_rd_req_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ar_hs),
    .push_data (push_req),
    .pop       (req_hs),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req_id  = head_req.id;
  assign req_len = head_req.len;
  assign req_ba  = head_req.ba;
  assign req_ra  = head_req.ra;
  assign req_ca  = head_req.ca;

  // A retirement with nothing in flight is a protocol error; the counter never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (ar_hs && !rd_done)
        outstanding <= outstanding + 1'b1;
      else if (!ar_hs && rd_done && outstanding != '0)
        outstanding <= outstanding - 1'b1;
      if ((ar_hs && proto_err) || (rd_done && outstanding == '0))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sal_ar_ingress.sv
// Self-checking bench for sal_ar_ingress: table-driven address decode plus hand-written
// backpressure, outstanding-cap, error and reset sequences, with a request scoreboard.
module tb_sal_ar_ingress;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [3:0]  req_len;
  logic [1:0]  req_ba;
  logic [13:0] req_ra;
  logic [9:0]  req_ca;
  logic        rd_done;
  logic [4:0]  outstanding;
  logic        err;

  typedef struct packed {
    logic [3:0]  id;
    logic [3:0]  len;
    logic [1:0]  ba;
    logic [13:0] ra;
    logic [9:0]  ca;
  } exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  sal_ar_ingress dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arvalid     (arvalid),
    .arready     (arready),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_id      (req_id),
    .req_len     (req_len),
    .req_ba      (req_ba),
    .req_ra      (req_ra),
    .req_ca      (req_ca),
    .rd_done     (rd_done),
    .outstanding (outstanding),
    .err         (err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t modelDecode(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.ca  = addr[13:4];
    e.ba  = addr[15:14];
    e.ra  = addr[29:16];
    return e;
  endfunction

  // Scoreboard: every request accepted by the scheduler must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_req", {req_id, req_len, req_ba, req_ra, req_ca}, 64'hDEAD);
      end else begin
        checkOutput("sb_req", {req_id, req_len, req_ba, req_ra, req_ca}, sb.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst_n     = 1'b0;
    arvalid   = 1'b0;
    req_ready = 1'b0;
    rd_done   = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = '0;
    arsize    = 3'd4;
    arburst   = 2'b01;
    sb.delete();
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Drives one AR beat and waits (bounded) for the handshake.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input exp_t e);
    int waited = 0;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!arready) begin
      checkOutput("ar_timeout", 64'd0, 64'd1);
      arvalid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic sendLegal(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    applyStimulus(id, addr, len, 3'd4, 2'b01, modelDecode(id, addr, len));
  endtask

  task automatic drain;
    req_ready = 1'b1;
    repeat (8) tick;
    req_ready = 1'b0;
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'h0, 32'h0000_0000, 4'h0, '{4'h0, 4'h0, 2'd0, 14'h0000, 10'h000}};
    vecs[1] = '{4'h1, 32'h0000_3FF0, 4'h0, '{4'h1, 4'h0, 2'd0, 14'h0000, 10'h3FF}};
    vecs[2] = '{4'h2, 32'h0000_4000, 4'h1, '{4'h2, 4'h1, 2'd1, 14'h0000, 10'h000}};
    vecs[3] = '{4'h3, 32'h0000_C000, 4'h2, '{4'h3, 4'h2, 2'd3, 14'h0000, 10'h000}};
    vecs[4] = '{4'h4, 32'h0001_0000, 4'h3, '{4'h4, 4'h3, 2'd0, 14'h0001, 10'h000}};
    vecs[5] = '{4'h5, 32'hFFFF_FFFF, 4'h0, '{4'h5, 4'h0, 2'd3, 14'h3FFF, 10'h3FF}};
    vecs[6] = '{4'hF, 32'h4000_000F, 4'hF, '{4'hF, 4'hF, 2'd0, 14'h0000, 10'h000}};
    vecs[7] = '{4'h7, 32'h1234_5670, 4'h2, '{4'h7, 4'h2, 2'd1, 14'h1234, 10'h167}};

    // Reset values, observed while reset is held.
    doReset;
    rst_n = 1'b0;
    tick;
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);

    // Single AR: request appears the cycle after the handshake.
    doReset;
    checkOutput("idle_arready", 64'(arready), 64'd1);
    applyStimulus(4'd3, 32'h0012_3450, 4'd3, 3'd4, 2'b01, '{4'd3, 4'd3, 2'd0, 14'h0012, 10'h345});
    checkOutput("single_req_valid", 64'(req_valid), 64'd1);
    checkOutput("single_fields", {req_id, req_len, req_ba, req_ra, req_ca},
                {4'd3, 4'd3, 2'd0, 14'h0012, 10'h345});
    checkOutput("single_outstanding", 64'(outstanding), 64'd1);
    drain;

    // Table-driven decode vectors, all legal.
    doReset;
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].id, vecs[i].addr, vecs[i].len, 3'd4, 2'b01, vecs[i].exp);
    drain;
    checkOutput("table_outstanding", 64'(outstanding), 64'd8);
    checkOutput("table_err", 64'(err), 64'd0);

    // Backpressure: four fill the FIFO, the fifth waits for one pop.
    doReset;
    for (int i = 0; i < 4; i++) sendLegal(4'(i), 32'(i) << 4, 4'd0);
    checkOutput("bp_head_ca", 64'(req_ca), 64'd0);
    arid = 4'd4; araddr = 32'h40; arvalid = 1'b1;
    @(negedge clk);
    checkOutput("bp_full_arready", 64'(arready), 64'd0);
    tick;
    checkOutput("bp_head_hold", 64'(req_id), 64'd0);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    checkOutput("bp_after_pop_arready", 64'(arready), 64'd1);
    sendLegal(4'd4, 32'h40, 4'd0);
    checkOutput("bp_full_again", 64'(arready), 64'd0);
    drain;

    // Outstanding cap at 16, released by one rd_done.
    doReset;
    req_ready = 1'b1;
    for (int i = 0; i < 16; i++) sendLegal(4'(i), 32'(i) << 8, 4'd1);
    arid = 4'd0; araddr = 32'h5000; arvalid = 1'b1;
    @(negedge clk);
    checkOutput("cap_outstanding", 64'(outstanding), 64'd16);
    checkOutput("cap_arready", 64'(arready), 64'd0);
    tick;
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    checkOutput("cap_release_outstanding", 64'(outstanding), 64'd15);
    checkOutput("cap_release_arready", 64'(arready), 64'd1);
    sendLegal(4'd0, 32'h5000, 4'd1);
    checkOutput("cap_refill", 64'(outstanding), 64'd16);
    drain;

    // Push+pop and AR+rd_done in the same cycle leave occupancy and count unchanged.
    doReset;
    sendLegal(4'd1, 32'h100, 4'd0);
    sendLegal(4'd2, 32'h200, 4'd0);
    req_ready = 1'b1;
    rd_done   = 1'b1;
    sendLegal(4'd3, 32'h300, 4'd0);
    req_ready = 1'b0;
    rd_done   = 1'b0;
    checkOutput("simul_outstanding", 64'(outstanding), 64'd2);
    sendLegal(4'd4, 32'h400, 4'd0);
    checkOutput("simul_occ3_arready", 64'(arready), 64'd1);
    sendLegal(4'd5, 32'h500, 4'd0);
    checkOutput("simul_occ4_arready", 64'(arready), 64'd0);
    drain;

    // Protocol errors are sticky and the request is still forwarded.
    doReset;
    req_ready = 1'b1;
    applyStimulus(4'd6, 32'h0000_1230, 4'd1, 3'd4, 2'b00, modelDecode(4'd6, 32'h0000_1230, 4'd1));
    checkOutput("err_fixed", 64'(err), 64'd1);
    drain;
    checkOutput("err_sticky", 64'(err), 64'd1);

    doReset;
    req_ready = 1'b1;
    sendLegal(4'd1, 32'h0000_3FC0, 4'd3);
    checkOutput("err_col_edge_ok", 64'(err), 64'd0);
    sendLegal(4'd2, 32'h0000_3FE0, 4'd3);
    checkOutput("err_col_cross", 64'(err), 64'd1);
    drain;

    doReset;
    req_ready = 1'b1;
    applyStimulus(4'd9, 32'h0000_0800, 4'd0, 3'd3, 2'b01, modelDecode(4'd9, 32'h0000_0800, 4'd0));
    checkOutput("err_size", 64'(err), 64'd1);
    drain;

    doReset;
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    checkOutput("err_underflow", 64'(err), 64'd1);
    checkOutput("underflow_outstanding", 64'(outstanding), 64'd0);

    // Reset with traffic queued and in flight drops everything.
    doReset;
    req_ready = 1'b1;
    for (int i = 0; i < 4; i++) sendLegal(4'(i), 32'(i) << 4, 4'd0);
    req_ready = 1'b0;
    sendLegal(4'd8, 32'h80, 4'd0);
    sendLegal(4'd9, 32'h90, 4'd0);
    applyStimulus(4'd10, 32'hA0, 4'd0, 3'd4, 2'b10, modelDecode(4'd10, 32'hA0, 4'd0));
    checkOutput("pre_rst_outstanding", 64'(outstanding), 64'd7);
    checkOutput("pre_rst_err", 64'(err), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    tick;
    checkOutput("mid_rst_req_valid", 64'(req_valid), 64'd0);
    checkOutput("mid_rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("mid_rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick;
    tick;
    checkOutput("post_rst_req_valid", 64'(req_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
